// File: rtl/axi_id_dest_tracker.sv
// Per-ID ordering guard for one AXI request channel (AR or AW): tracks outstanding count and
// destination slave per ID, and stalls a request whose ID is still in flight to another slave.
module axi_id_dest_tracker #(
    parameter int ID_WIDTH        = 4,
    parameter int EXT_SLAVES      = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ID_WIDTH-1:0]   req_id,
    input  logic [EXT_SLAVES-1:0] req_slaves,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXT_SLAVES-1:0] out_slaves,
    output logic                  out_decerr,
    input  logic                  cpl_valid,
    input  logic [ID_WIDTH-1:0]   cpl_id,
    output logic                  cpl_err,
    output logic                  busy
);

    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int NUM_IDS = 1 << ID_WIDTH;

    logic [CNT_W-1:0]      cnt     [NUM_IDS];
    logic [EXT_SLAVES-1:0] dst     [NUM_IDS];
    logic [CNT_W-1:0]      cnt_nxt [NUM_IDS];
    logic [EXT_SLAVES-1:0] sel;
    logic                  allow;
    logic                  accept;
    logic                  busy_nxt;

    // Lowest set bit wins when address ranges overlap; zero means decode error.
    assign sel        = req_slaves & (~req_slaves + EXT_SLAVES'(1));
    assign out_slaves = sel;
    assign out_decerr = (req_slaves == '0);

    assign allow = (cnt[req_id] == '0) |
                   ((dst[req_id] == sel) & (cnt[req_id] != CNT_W'(MAX_OUTSTANDING)));

    // Handshake: a request transfers on a cycle where req_valid & req_ready are both high.
    // out_valid never waits on out_ready and req_ready never waits on req_valid, so the
    // guard adds no combinational loop between the two sides.
    assign out_valid = ~rst & req_valid & allow;
    assign req_ready = ~rst & out_ready & allow;
    assign accept    = req_valid & req_ready;

    always_comb begin
        busy_nxt = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) begin
            cnt_nxt[i] = cnt[i];
            if (accept && (req_id == ID_WIDTH'(i))) begin
                if (!(cpl_valid && (cpl_id == ID_WIDTH'(i)) && (cnt[i] != '0)))
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end else if (cpl_valid && (cpl_id == ID_WIDTH'(i)) && (cnt[i] != '0)) begin
                cnt_nxt[i] = cnt[i] - CNT_W'(1);
            end
            busy_nxt = busy_nxt | (cnt_nxt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                cnt[i] <= '0;
                dst[i] <= '0;
            end
            cpl_err <= 1'b0;
            busy    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_IDS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            if (accept)
                dst[req_id] <= sel;
            cpl_err <= cpl_valid & (cnt[cpl_id] == '0);
            busy    <= busy_nxt;
        end
    end

endmodule
